harmonic_sequencer: RTL and testbench



---
 rtl/harmonic_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_harmonic_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic scheduler: walks the harmonics through the phase RAM, sine LUT
// and fraction adder, then scales the total into one DAC word per sample tick.
module harmonic_sequencer #(
   parameter int          SAMPLE_INTERVAL = 1500,
   parameter int          MAX_HARMONICS   = 64,
   parameter int          DIV_BIT         = 7,
   parameter logic [31:0] OUT_OFFSET      = 32'h21000,
   parameter logic [7:0]  DAC_CMD         = 8'h31
) (
   input  logic               clock,
   input  logic               rstn,
   input  logic [15:0]        frequency,
   input  logic [7:0]         harmonic_count,
   input  logic [DIV_BIT-1:0] amp_start,
   input  logic [DIV_BIT-1:0] amp_step,
   output logic [7:0]         pos_addr,
   input  logic [15:0]        pos_rdata,
   output logic [15:0]        pos_wdata,
   output logic               pos_we,
   output logic [10:0]        lut_addr,
   output logic               adder_start,
   output logic               adder_clear,
   output logic [DIV_BIT-1:0] adder_mult,
   input  logic               adder_ready,
   input  logic [31:0]        adder_total,
   output logic [23:0]        dac_data,
   output logic               dac_send,
   output logic               busy,
   output logic               overrun
);

   localparam int                 TIMER_W    = $clog2(SAMPLE_INTERVAL);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_INTERVAL - 1);
   localparam logic [7:0]         MAX_N      = 8'(MAX_HARMONICS);
   localparam logic [16:0]        NYQUIST    = 17'h08000;

   localparam logic [3:0] S_INIT      = 4'd0;
   localparam logic [3:0] S_READ      = 4'd1;
   localparam logic [3:0] S_UPDATE    = 4'd2;
   localparam logic [3:0] S_SETTLE    = 4'd3;
   localparam logic [3:0] S_ISSUE     = 4'd4;
   localparam logic [3:0] S_DRAIN     = 4'd5;
   localparam logic [3:0] S_FINISH    = 4'd6;
   localparam logic [3:0] S_WAIT_TICK = 4'd7;
   localparam logic [3:0] S_SEND      = 4'd8;

   logic [3:0]         state;
   logic [TIMER_W-1:0] sample_timer;
   logic               pending;
   logic               tick;
   logic [15:0]        freq_l;
   logic [7:0]         n_l;
   logic [7:0]         h;
   logic [16:0]        inc;
   logic [DIV_BIT-1:0] step_l;
   logic               settle_cnt;
   logic               drain_armed;
   logic [15:0]        sample;

   logic [7:0]         n_clamped;
   logic [15:0]        phase_sum;
   logic [16:0]        inc_next;
   logic [7:0]         h_next;
   logic               last_harm;
   logic signed [31:0] t_sum;
   logic signed [31:0] t_shift;
   logic [15:0]        sample_sat;

   assign tick      = (sample_timer == TIMER_LAST);
   assign phase_sum = pos_rdata + inc[15:0];
   assign inc_next  = inc + {1'b0, freq_l};
   assign h_next    = h + 8'd1;
   // Stop at the requested count or once the next harmonic would alias.
   assign last_harm = (h_next == n_l) || (inc_next >= NYQUIST);
   assign t_sum     = $signed(adder_total) + $signed(OUT_OFFSET);
   assign t_shift   = t_sum >>> 2;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      n_clamped = harmonic_count;
      if (harmonic_count == 8'd0)
         n_clamped = 8'd1;
      else if (harmonic_count > MAX_N)
         n_clamped = MAX_N;
   end

   always_comb begin
      sample_sat = t_shift[15:0];
      if (t_shift < 32'sd0)
         sample_sat = 16'h0000;
      else if (t_shift > 32'sd65535)
         sample_sat = 16'hFFFF;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn)
         sample_timer <= '0;
      else if (tick)
         sample_timer <= '0;
      else
         sample_timer <= sample_timer + 1'b1;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state       <= S_INIT;
         pending     <= 1'b0;
         freq_l      <= '0;
         n_l         <= '0;
         h           <= '0;
         inc         <= '0;
         step_l      <= '0;
         settle_cnt  <= 1'b0;
         drain_armed <= 1'b0;
         sample      <= '0;
         pos_addr    <= '0;
         pos_wdata   <= '0;
         pos_we      <= 1'b0;
         lut_addr    <= '0;
         adder_start <= 1'b0;
         adder_clear <= 1'b0;
         adder_mult  <= '0;
         dac_data    <= '0;
         dac_send    <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
         pos_we      <= 1'b0;
         adder_start <= 1'b0;
         adder_clear <= 1'b0;
         dac_send    <= 1'b0;
         overrun     <= 1'b0;

         // The fraction moves on only after its start pulse, keeping it stable during the pulse.
         if (adder_start && (adder_mult > step_l))
            adder_mult <= adder_mult - step_l;

         if (tick && (state != S_WAIT_TICK) && (state != S_SEND)) begin
            pending <= 1'b1;
            overrun <= 1'b1;
         end

         case (state)
            S_INIT: begin
               freq_l      <= frequency;
               n_l         <= n_clamped;
               step_l      <= amp_step;
               inc         <= {1'b0, frequency};
               h           <= '0;
               adder_mult  <= amp_start;
               pos_addr    <= '0;
               busy        <= 1'b1;
               drain_armed <= 1'b0;
               state       <= S_READ;
            end
            S_READ:
               state <= S_UPDATE;
            S_UPDATE: begin
               pos_wdata  <= phase_sum;
               pos_we     <= 1'b1;
               lut_addr   <= phase_sum[15:5];
               settle_cnt <= 1'b0;
               state      <= S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_cnt)
                  state <= S_ISSUE;
               else
                  settle_cnt <= 1'b1;
            end
            S_ISSUE: begin
               if (adder_ready) begin
                  adder_start <= 1'b1;
                  h           <= h_next;
                  pos_addr    <= h_next;
                  inc         <= inc_next;
                  state       <= last_harm ? S_DRAIN : S_READ;
               end
            end
            S_DRAIN: begin
               // adder_ready is still the pre-start value in the first DRAIN cycle.
               if (!drain_armed)
                  drain_armed <= 1'b1;
               else if (adder_ready)
                  state <= S_FINISH;
            end
            S_FINISH: begin
               sample <= sample_sat;
               busy   <= 1'b0;
               state  <= (pending || tick) ? S_SEND : S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
               if (tick)
                  state <= S_SEND;
            end
            S_SEND: begin
               dac_data    <= {DAC_CMD, sample};
               dac_send    <= 1'b1;
               adder_clear <= 1'b1;
               pending     <= 1'b0;
               state       <= S_INIT;
            end
            default:
               state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed-vector bench for harmonic_sequencer with behavioural phase RAM and adder models.
module tb_harmonic_sequencer;

   localparam int DIV_BIT = 7;

   logic               clock = 1'b0;
   logic               rstn  = 1'b0;
   logic [15:0]        frequency = '0;
   logic [7:0]         harmonic_count = '0;
   logic [DIV_BIT-1:0] amp_start = '0;
   logic [DIV_BIT-1:0] amp_step = '0;
   logic [7:0]         pos_addr;
   logic [15:0]        pos_rdata = '0;
   logic [15:0]        pos_wdata;
   logic               pos_we;
   logic [10:0]        lut_addr;
   logic               adder_start;
   logic               adder_clear;
   logic [DIV_BIT-1:0] adder_mult;
   logic               adder_ready;
   logic [31:0]        adder_total;
   logic [23:0]        dac_data;
   logic               dac_send;
   logic               busy;
   logic               overrun;

   harmonic_sequencer dut (
      .clock          (clock),
      .rstn           (rstn),
      .frequency      (frequency),
      .harmonic_count (harmonic_count),
      .amp_start      (amp_start),
      .amp_step       (amp_step),
      .pos_addr       (pos_addr),
      .pos_rdata      (pos_rdata),
      .pos_wdata      (pos_wdata),
      .pos_we         (pos_we),
      .lut_addr       (lut_addr),
      .adder_start    (adder_start),
      .adder_clear    (adder_clear),
      .adder_mult     (adder_mult),
      .adder_ready    (adder_ready),
      .adder_total    (adder_total),
      .dac_data       (dac_data),
      .dac_send       (dac_send),
      .busy           (busy),
      .overrun        (overrun)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   always @(posedge clock) cycle <= cycle + 1;

   // Phase RAM model: registered read, write-through on pos_we, bulk init on request.
   logic [15:0] mem [256];
   logic        init_req  = 1'b0;
   logic [15:0] init_val0 = '0;

   always @(posedge clock) begin
      if (init_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[0] <= init_val0;
      end else begin
         pos_rdata <= mem[pos_addr];
         if (pos_we) mem[pos_addr] <= pos_wdata;
      end
   end

   // Adder model: busy for three clocks after each start, plus a forced stall.
   int   adder_cnt = 0;
   logic force_low = 1'b0;
   logic [31:0] total_drv = '0;

   always @(posedge clock) begin
      if (adder_start) adder_cnt <= 3;
      else if (adder_cnt != 0) adder_cnt <= adder_cnt - 1;
   end
   assign adder_ready = (adder_cnt == 0) && !force_low;
   assign adder_total = total_drv;

   // Event logs, sampled on the falling edge.
   int                 send_cyc_q[$];
   logic [23:0]        send_data_q[$];
   int                 send_wr_q[$];
   int                 send_st_q[$];
   logic [7:0]         wr_addr_q[$];
   logic [15:0]        wr_data_q[$];
   logic [10:0]        wr_lut_q[$];
   logic [DIV_BIT-1:0] mult_q[$];
   int                 ovr_cnt = 0;
   int                 clr_cnt = 0;

   always @(negedge clock) begin
      if (pos_we) begin
         wr_addr_q.push_back(pos_addr);
         wr_data_q.push_back(pos_wdata);
         wr_lut_q.push_back(lut_addr);
      end
      if (adder_start) mult_q.push_back(adder_mult);
      if (dac_send) begin
         send_cyc_q.push_back(cycle);
         send_data_q.push_back(dac_data);
         send_wr_q.push_back(wr_addr_q.size());
         send_st_q.push_back(mult_q.size());
      end
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (adder_clear) clr_cnt <= clr_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input logic [15:0] f, input logic [7:0] cnt,
                           input logic [DIV_BIT-1:0] as, input logic [DIV_BIT-1:0] st,
                           input logic [15:0] ram0);
      rstn           = 1'b0;
      force_low      = 1'b0;
      frequency      = f;
      harmonic_count = cnt;
      amp_start      = as;
      amp_step       = st;
      init_val0      = ram0;
      init_req       = 1'b1;
      @(posedge clock);
      #1 init_req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      rstn = 1'b1;
   endtask

   task automatic wait_sends(input int n, input int budget, input string tag, output bit ok);
      int k = 0;
      while (send_cyc_q.size() < n && k < budget) begin
         @(negedge clock);
         #1;
         k++;
      end
      ok = (send_cyc_q.size() >= n);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s timeout: sends seen %0d required %0d", tag, send_cyc_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #3;
      n_checks++;
      if ({pos_addr, pos_wdata, pos_we, lut_addr, adder_start, adder_clear, adder_mult,
           dac_data, dac_send, busy, overrun} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got nonzero outputs busy=%b dac_data=%h required all 0",
                  busy, dac_data);
      end
      do_reset(16'd500, 8'd2, 7'd90, 7'd5, 16'd0);
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b1 || pos_addr !== 8'd0 || adder_mult !== 7'd90) begin
         n_fail++;
         $display("FAIL init_state: busy=%b pos_addr=%0d mult=%0d required 1/0/90",
                  busy, pos_addr, adder_mult);
      end
      n_checks++;
      if (pos_we !== 1'b0 || dac_send !== 1'b0) begin
         n_fail++;
         $display("FAIL init_quiet: pos_we=%b dac_send=%b required 0/0", pos_we, dac_send);
      end
   endtask

   task automatic test_basic();
      int exp_w[6] = '{1000, 2000, 3000, 2000, 4000, 6000};
      int exp_m[6] = '{127, 117, 107, 127, 117, 107};
      int wb, mb, sb, cb;
      bit ok;
      total_drv = 32'd0;
      do_reset(16'd1000, 8'd3, 7'd127, 7'd10, 16'd0);
      wb = wr_addr_q.size(); mb = mult_q.size(); sb = send_cyc_q.size(); cb = clr_cnt;
      wait_sends(sb + 3, 6000, "basic_sends", ok);
      if (!ok) return;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (wr_addr_q[wb+i] !== 8'(i % 3) || wr_data_q[wb+i] !== 16'(exp_w[i])) begin
            n_fail++;
            $display("FAIL basic_write[%0d]: addr=%0d data=%0d required addr=%0d data=%0d",
                     i, wr_addr_q[wb+i], wr_data_q[wb+i], i % 3, exp_w[i]);
         end
         n_checks++;
         if (mult_q[mb+i] !== 7'(exp_m[i])) begin
            n_fail++;
            $display("FAIL basic_mult[%0d]: got %0d required %0d", i, mult_q[mb+i], exp_m[i]);
         end
      end
      n_checks++;
      if (wr_lut_q[wb] !== 11'd31 || wr_lut_q[wb+2] !== 11'd93) begin
         n_fail++;
         $display("FAIL basic_lut: got %0d,%0d required 31,93", wr_lut_q[wb], wr_lut_q[wb+2]);
      end
      n_checks++;
      if (send_wr_q[sb] - wb !== 3 || send_wr_q[sb+1] - send_wr_q[sb] !== 3) begin
         n_fail++;
         $display("FAIL basic_writes_per_sample: got %0d,%0d required 3,3",
                  send_wr_q[sb] - wb, send_wr_q[sb+1] - send_wr_q[sb]);
      end
      n_checks++;
      if (send_st_q[sb+1] - send_st_q[sb] !== 3) begin
         n_fail++;
         $display("FAIL basic_starts_per_sample: got %0d required 3",
                  send_st_q[sb+1] - send_st_q[sb]);
      end
      n_checks++;
      if (send_cyc_q[sb+1] - send_cyc_q[sb] !== 1500 || send_cyc_q[sb+2] - send_cyc_q[sb+1] !== 1500) begin
         n_fail++;
         $display("FAIL basic_period: got %0d,%0d required 1500,1500",
                  send_cyc_q[sb+1] - send_cyc_q[sb], send_cyc_q[sb+2] - send_cyc_q[sb+1]);
      end
      n_checks++;
      if (send_data_q[sb] !== 24'h318400) begin
         n_fail++;
         $display("FAIL basic_dac_data: got %h required 318400", send_data_q[sb]);
      end
      n_checks++;
      if (clr_cnt - cb !== 3) begin
         n_fail++;
         $display("FAIL basic_clear_count: got %0d required 3", clr_cnt - cb);
      end
   endtask

   task automatic test_nyquist();
      int wb, mb, sb;
      bit ok;
      do_reset(16'd12000, 8'd8, 7'd64, 7'd1, 16'd0);
      wb = wr_addr_q.size(); mb = mult_q.size(); sb = send_cyc_q.size();
      wait_sends(sb + 1, 3100, "nyquist_send", ok);
      if (!ok) return;
      n_checks++;
      if (send_wr_q[sb] - wb !== 2 || send_st_q[sb] - mb !== 2) begin
         n_fail++;
         $display("FAIL nyquist_count: writes=%0d starts=%0d required 2/2",
                  send_wr_q[sb] - wb, send_st_q[sb] - mb);
      end
      n_checks++;
      if (wr_addr_q[wb] !== 8'd0 || wr_data_q[wb] !== 16'd12000 ||
          wr_addr_q[wb+1] !== 8'd1 || wr_data_q[wb+1] !== 16'd24000) begin
         n_fail++;
         $display("FAIL nyquist_writes: %0d@%0d %0d@%0d required 12000@0 24000@1",
                  wr_data_q[wb], wr_addr_q[wb], wr_data_q[wb+1], wr_addr_q[wb+1]);
      end
   endtask

   task automatic test_phase_wrap();
      int wb, sb;
      bit ok;
      do_reset(16'd1000, 8'd1, 7'd100, 7'd1, 16'd65000);
      wb = wr_addr_q.size(); sb = send_cyc_q.size();
      wait_sends(sb + 1, 3100, "wrap_send", ok);
      if (!ok) return;
      n_checks++;
      if (wr_addr_q[wb] !== 8'd0 || wr_data_q[wb] !== 16'd464 || wr_lut_q[wb] !== 11'd14) begin
         n_fail++;
         $display("FAIL phase_wrap: addr=%0d data=%0d lut=%0d required 0/464/14",
                  wr_addr_q[wb], wr_data_q[wb], wr_lut_q[wb]);
      end
      n_checks++;
      if (send_wr_q[sb] - wb !== 1) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d required 1", send_wr_q[sb] - wb);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] totals[4] = '{-32'sd200000, 32'sd300000, -32'sd100001, 32'sd0};
      logic [23:0] exp_d[4]  = '{24'h310000, 24'h31FFFF, 24'h312257, 24'h318400};
      int sb;
      bit ok;
      total_drv = totals[0];
      do_reset(16'd1000, 8'd1, 7'd100, 7'd1, 16'd0);
      sb = send_cyc_q.size();
      for (int i = 0; i < 4; i++) begin
         wait_sends(sb + i + 1, 3100, "sat_send", ok);
         if (!ok) return;
         n_checks++;
         if (send_data_q[sb+i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL saturation[%0d]: got %h required %h", i, send_data_q[sb+i], exp_d[i]);
         end
         if (i < 3) total_drv = totals[i+1];
      end
      total_drv = 32'd0;
   endtask

   task automatic test_overrun();
      int sb, ob, rel;
      bit ok;
      do_reset(16'd1000, 8'd3, 7'd127, 7'd10, 16'd0);
      sb = send_cyc_q.size();
      wait_sends(sb + 1, 3100, "ovr_first", ok);
      if (!ok) return;
      force_low = 1'b1;
      ob = ovr_cnt;
      repeat (1000) @(negedge clock);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_busy: got %b required 1", busy);
      end
      repeat (1000) @(negedge clock);
      force_low = 1'b0;
      rel = cycle;
      wait_sends(sb + 2, 200, "ovr_pending_send", ok);
      if (!ok) return;
      n_checks++;
      if (ovr_cnt - ob !== 1) begin
         n_fail++;
         $display("FAIL ovr_pulses: got %0d required 1", ovr_cnt - ob);
      end
      n_checks++;
      if (send_cyc_q[sb+1] - rel <= 0 || send_cyc_q[sb+1] - rel > 60) begin
         n_fail++;
         $display("FAIL ovr_send_latency: got %0d required 1..60", send_cyc_q[sb+1] - rel);
      end
      n_checks++;
      if (send_st_q[sb+1] - send_st_q[sb] !== 3) begin
         n_fail++;
         $display("FAIL ovr_starts: got %0d required 3", send_st_q[sb+1] - send_st_q[sb]);
      end
      wait_sends(sb + 3, 3100, "ovr_realign", ok);
      if (!ok) return;
      n_checks++;
      if (send_cyc_q[sb+2] - send_cyc_q[sb] !== 3000) begin
         n_fail++;
         $display("FAIL ovr_alignment: got %0d required 3000", send_cyc_q[sb+2] - send_cyc_q[sb]);
      end
      n_checks++;
      if (ovr_cnt - ob !== 1) begin
         n_fail++;
         $display("FAIL ovr_no_extra: got %0d required 1", ovr_cnt - ob);
      end
   endtask

   task automatic test_reset_mid();
      int wb, sb, k;
      do_reset(16'd1000, 8'd3, 7'd127, 7'd10, 16'd0);
      force_low = 1'b1;
      repeat (20) @(negedge clock);
      n_checks++;
      if (busy !== 1'b1 || mem[0] !== 16'd1000) begin
         n_fail++;
         $display("FAIL mid_pre_state: busy=%b ram0=%0d required 1/1000", busy, mem[0]);
      end
      wb = wr_addr_q.size(); sb = send_cyc_q.size();
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({pos_addr, pos_wdata, pos_we, lut_addr, adder_start, adder_clear, adder_mult,
           dac_data, dac_send, busy, overrun} !== '0) begin
         n_fail++;
         $display("FAIL mid_async_reset: busy=%b pos_addr=%0d lut=%0d required all 0",
                  busy, pos_addr, lut_addr);
      end
      force_low = 1'b0;
      repeat (2) @(negedge clock);
      rstn = 1'b1;
      @(negedge clock);
      n_checks++;
      if (pos_we !== 1'b0 || busy !== 1'b1 || pos_addr !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_restart: pos_we=%b busy=%b pos_addr=%0d required 0/1/0",
                  pos_we, busy, pos_addr);
      end
      k = 0;
      while (wr_addr_q.size() <= wb && k < 50) begin
         @(negedge clock);
         #1;
         k++;
      end
      n_checks++;
      if (wr_addr_q.size() <= wb) begin
         n_fail++;
         $display("FAIL mid_first_write: no write within 50 clocks required one");
      end else if (wr_addr_q[wb] !== 8'd0 || wr_data_q[wb] !== 16'd2000) begin
         n_fail++;
         $display("FAIL mid_first_write: %0d@%0d required 2000@0", wr_data_q[wb], wr_addr_q[wb]);
      end
      n_checks++;
      if (send_cyc_q.size() !== sb) begin
         n_fail++;
         $display("FAIL mid_no_send: got %0d sends required 0", send_cyc_q.size() - sb);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_nyquist();
      test_phase_wrap();
      test_saturation();
      test_overrun();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
